// File: rtl/phase_sequencer.sv
// phase_sequencer: multi-cycle core controller that walks an instruction through
// fetch, decode, execute, memory and writeback. It holds a phase while that
// stage stalls, supports run/halt and flush restart, and keeps cycle and
// retired-instruction counters plus a sticky stall-timeout flag.
module phase_sequencer #(
   parameter int CNT_WIDTH     = 32,
   parameter int STALL_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 flush,
   input  logic                 stall_fetch,
   input  logic                 stall_decode,
   input  logic                 stall_execute,
   input  logic                 stall_memory,
   input  logic                 stall_writeback,
   output logic                 phase_fetch,
   output logic                 phase_decode,
   output logic                 phase_execute,
   output logic                 phase_memory,
   output logic                 phase_writeback,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] cycle,
   output logic [CNT_WIDTH-1:0] instret,
   output logic                 timeout_err
);

   localparam int SW = $clog2(STALL_TIMEOUT + 1);
   localparam logic [SW-1:0]        STALL_MAX = SW'(STALL_TIMEOUT);
   localparam logic [SW-1:0]        STALL_ONE = SW'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXECUTE,
      MEMORY,
      WRITEBACK
   } state_t;

   state_t        state;
   state_t        next_state;
   logic          cur_stall;
   logic          hold;
   logic          retire;
   logic [SW-1:0] stall_cnt;

   // Select the stall flag belonging to the phase we are currently in.
   always_comb begin
      cur_stall = 1'b0;
      case (state)
         FETCH:     cur_stall = stall_fetch;
         DECODE:    cur_stall = stall_decode;
         EXECUTE:   cur_stall = stall_execute;
         MEMORY:    cur_stall = stall_memory;
         WRITEBACK: cur_stall = stall_writeback;
         default:   cur_stall = 1'b0;
      endcase
   end

   // Next-state selection: flush beats stall, stall beats advancing.
   always_comb begin
      next_state = state;
      hold       = 1'b0;
      retire     = 1'b0;
      if (state == IDLE) begin
         next_state = run ? FETCH : IDLE;
      end else if (flush) begin
         next_state = run ? FETCH : IDLE;
      end else if (cur_stall) begin
         hold = 1'b1;
      end else begin
         case (state)
            FETCH:     next_state = DECODE;
            DECODE:    next_state = EXECUTE;
            EXECUTE:   next_state = MEMORY;
            MEMORY:    next_state = WRITEBACK;
            WRITEBACK: begin
               retire     = 1'b1;
               next_state = run ? FETCH : IDLE;
            end
            default:   next_state = IDLE;
         endcase
      end
   end

   // State, registered phase enables, counters and the stall watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         phase_fetch     <= 1'b0;
         phase_decode    <= 1'b0;
         phase_execute   <= 1'b0;
         phase_memory    <= 1'b0;
         phase_writeback <= 1'b0;
         busy            <= 1'b0;
         cycle           <= '0;
         instret         <= '0;
         timeout_err     <= 1'b0;
         stall_cnt       <= '0;
      end else begin
         state           <= next_state;
         phase_fetch     <= (next_state == FETCH);
         phase_decode    <= (next_state == DECODE);
         phase_execute   <= (next_state == EXECUTE);
         phase_memory    <= (next_state == MEMORY);
         phase_writeback <= (next_state == WRITEBACK);
         busy            <= (next_state != IDLE);
         if (state != IDLE) begin
            cycle <= cycle + CNT_ONE;
         end
         if (retire) begin
            instret <= instret + CNT_ONE;
         end
         if (hold) begin
            if (stall_cnt != STALL_MAX) begin
               stall_cnt <= stall_cnt + STALL_ONE;
            end
            if (stall_cnt == STALL_MAX - STALL_ONE) begin
               timeout_err <= 1'b1;
            end
         end else begin
            stall_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: randomized scoreboard bench. The driver predicts each
// post-edge output snapshot from an instruction-level model and queues it;
// the monitor pops one snapshot after every rising edge and compares.
module tb_phase_sequencer;

   localparam int CW = 4;
   localparam int TO = 16;
   localparam int MODV = 1 << CW;

   logic          clk;
   logic          rst;
   logic          run;
   logic          flush;
   logic          stall_fetch;
   logic          stall_decode;
   logic          stall_execute;
   logic          stall_memory;
   logic          stall_writeback;
   logic          phase_fetch;
   logic          phase_decode;
   logic          phase_execute;
   logic          phase_memory;
   logic          phase_writeback;
   logic          busy;
   logic [CW-1:0] cycle;
   logic [CW-1:0] instret;
   logic          timeout_err;

   int total;
   int bad;

   // Reference model: phase number (0 = idle, 1..5 = fetch..writeback) and counters.
   int m_ph;
   int m_cyc;
   int m_ir;
   int m_scnt;
   bit m_terr;

   logic [14:0] exp_q[$];

   phase_sequencer #(.CNT_WIDTH(CW), .STALL_TIMEOUT(TO)) dut (
      .clk(clk),
      .rst(rst),
      .run(run),
      .flush(flush),
      .stall_fetch(stall_fetch),
      .stall_decode(stall_decode),
      .stall_execute(stall_execute),
      .stall_memory(stall_memory),
      .stall_writeback(stall_writeback),
      .phase_fetch(phase_fetch),
      .phase_decode(phase_decode),
      .phase_execute(phase_execute),
      .phase_memory(phase_memory),
      .phase_writeback(phase_writeback),
      .busy(busy),
      .cycle(cycle),
      .instret(instret),
      .timeout_err(timeout_err)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [14:0] model_snapshot();
      logic [4:0] onehot;
      onehot = 5'b0;
      if (m_ph != 0) onehot[m_ph-1] = 1'b1;
      return {onehot, (m_ph != 0), 4'(m_cyc), 4'(m_ir), m_terr};
   endfunction

   function automatic logic [14:0] dut_snapshot();
      return {phase_writeback, phase_memory, phase_execute, phase_decode, phase_fetch,
              busy, cycle, instret, timeout_err};
   endfunction

   task automatic check_output(input string name, input logic [14:0] act, input logic [14:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ph = 0; m_cyc = 0; m_ir = 0; m_scnt = 0; m_terr = 0;
   endtask

   // Advance the model by one rising edge using the given inputs.
   task automatic model_step(input bit r, input bit fl, input logic [4:0] st);
      if (m_ph != 0) m_cyc = (m_cyc + 1) % MODV;
      if (m_ph == 0) begin
         m_ph = r ? 1 : 0;
         m_scnt = 0;
      end else if (fl) begin
         m_ph = r ? 1 : 0;
         m_scnt = 0;
      end else if (st[m_ph-1]) begin
         if (m_scnt < TO) m_scnt++;
         if (m_scnt == TO) m_terr = 1;
      end else begin
         m_scnt = 0;
         if (m_ph == 5) begin
            m_ir = (m_ir + 1) % MODV;
            m_ph = r ? 1 : 0;
         end else begin
            m_ph++;
         end
      end
   endtask

   // Called at a falling edge: drive inputs, predict, queue, wait one cycle.
   task automatic apply_stimulus(input bit r, input bit fl, input logic [4:0] st);
      run = r;
      flush = fl;
      {stall_writeback, stall_memory, stall_execute, stall_decode, stall_fetch} = st;
      model_step(r, fl, st);
      exp_q.push_back(model_snapshot());
      @(negedge clk);
   endtask

   task automatic random_cycles(input int n);
      logic [4:0] st;
      bit r, fl;
      for (int i = 0; i < n; i++) begin
         r  = ($urandom_range(0, 9) != 0);
         fl = ($urandom_range(0, 19) == 0);
         for (int k = 0; k < 5; k++) st[k] = ($urandom_range(0, 3) == 0);
         apply_stimulus(r, fl, st);
      end
   endtask

   // Monitor: after each rising edge, compare the DUT against the next queued prediction.
   initial begin
      logic [14:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("cycle_snapshot", dut_snapshot(), e);
         end
      end
   end

   initial begin
      int guard;
      total = 0;
      bad = 0;
      model_reset();
      rst = 1'b1;
      run = 1'b0;
      flush = 1'b0;
      {stall_writeback, stall_memory, stall_execute, stall_decode, stall_fetch} = 5'b0;
      @(negedge clk);
      check_output("reset_state", dut_snapshot(), 15'b0);
      rst = 1'b0;

      // Flush while idle must do nothing, then a clean unstalled instruction.
      apply_stimulus(1'b0, 1'b1, 5'b0);
      for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b0, 5'b0);
      // Memory stalls for three cycles.
      apply_stimulus(1'b1, 1'b0, 5'b0);
      apply_stimulus(1'b1, 1'b0, 5'b0);
      apply_stimulus(1'b1, 1'b0, 5'b0);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 5'b01000);
      apply_stimulus(1'b1, 1'b0, 5'b0);
      // Run drops mid-instruction: finish then park.
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 5'b0);
      for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 5'b0);

      // Long unstalled run to wrap both 4-bit counters.
      for (int i = 0; i < 90; i++) apply_stimulus(1'b1, 1'b0, 5'b0);
      random_cycles(300);

      // Hold every stall high long enough to trip the watchdog, then release.
      apply_stimulus(1'b1, 1'b0, 5'b0);
      for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0, 5'b11111);
      random_cycles(40);

      // Walk to MEMORY, then pulse reset between edges.
      guard = 0;
      while (m_ph != 4 && guard < 12) begin
         apply_stimulus(1'b1, 1'b0, 5'b0);
         guard++;
      end
      total++;
      if (m_ph != 4) begin
         bad++;
         $display("[TB] FAIL reach_memory: model phase %0d required 4", m_ph);
      end
      #2;
      rst = 1'b1;
      #1;
      check_output("async_reset", dut_snapshot(), 15'b0);
      model_reset();
      exp_q.push_back(model_snapshot());
      @(negedge clk);
      rst = 1'b0;
      random_cycles(60);

      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: %0d left required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
